// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch state encoding and the PC helper functions.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

    // Wraps modulo 2^32 with no carry out.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch_stage and memory.
// The fetch side (master) issues the request; memory (slave) completes it.
interface fetch_stage_if;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemData
    );

endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry store for an instruction (and its PC) that returned while
// the IF/ID register was stalled.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    // A load in the same cycle as a clear wins: it carries newer data.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end
        if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory
// handshake and delivers one registered instruction per cycle to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Stall,
    input  logic                 Redirect,
    input  logic [31:0]          RedirectTarget,
    fetch_stage_if.master        imem,
    output logic [31:0]          Instruction,
    output logic [31:0]          InstrPC,
    output logic [31:0]          InstrPCPlus4,
    output logic                 InstrValid
);

    localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h0000_0003;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;
    logic         req_q, req_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  plus4_q, plus4_d;
    logic         valid_q, valid_d;

    logic         skid_load, skid_clear;
    logic [31:0]  skid_instr, skid_pc;
    logic         skid_valid;

    logic         bubble;
    logic [31:0]  bubble_pc;
    logic [31:0]  target;

    assign target = align_pc(RedirectTarget);

    fetch_skid_buffer u_skid (
        .clk      (Clock),
        .rst_n    (Reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (imem.IMemData),
        .pc_in    (fetch_pc_q),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .valid    (skid_valid)
    );

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        plus4_d      = plus4_q;
        valid_d      = valid_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        bubble       = 1'b0;
        bubble_pc    = fetch_pc_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                bubble  = 1'b1;
                if (Redirect) begin
                    fetch_pc_d = target;
                    bubble_pc  = target;
                end
            end

            FETCH: begin
                if (Redirect) begin
                    bubble    = 1'b1;
                    bubble_pc = target;
                    if (imem.IMemReady) begin
                        fetch_pc_d = target;
                    end else begin
                        pending_pc_d = target;
                        state_d      = DRAIN;
                    end
                end else if (imem.IMemReady) begin
                    fetch_pc_d = next_pc(fetch_pc_q);
                    if (Stall) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        instr_d    = imem.IMemData;
                        instr_pc_d = fetch_pc_q;
                        plus4_d    = next_pc(fetch_pc_q);
                        valid_d    = 1'b1;
                    end
                end else if (!Stall) begin
                    bubble = 1'b1;
                end
            end

            HOLD: begin
                if (Redirect) begin
                    skid_clear = 1'b1;
                    fetch_pc_d = target;
                    bubble     = 1'b1;
                    bubble_pc  = target;
                    state_d    = FETCH;
                end else if (!Stall) begin
                    instr_d    = skid_instr;
                    instr_pc_d = skid_pc;
                    plus4_d    = next_pc(skid_pc);
                    valid_d    = skid_valid;
                    skid_clear = 1'b1;
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                // The in-flight response belongs to the abandoned path; drop it.
                if (Redirect) begin
                    bubble    = 1'b1;
                    bubble_pc = target;
                    if (imem.IMemReady) begin
                        fetch_pc_d = target;
                        state_d    = FETCH;
                    end else begin
                        pending_pc_d = target;
                    end
                end else begin
                    bubble_pc = pending_pc_q;
                    bubble    = !Stall;
                    if (imem.IMemReady) begin
                        fetch_pc_d = pending_pc_q;
                        state_d    = FETCH;
                    end
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        if (bubble) begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            instr_pc_d = bubble_pc;
            plus4_d    = next_pc(bubble_pc);
        end
    end

    assign req_d = (state_d == FETCH) || (state_d == DRAIN);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= BOOT;
            fetch_pc_q   <= BOOT_PC;
            pending_pc_q <= 32'h0;
            req_q        <= 1'b0;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= 32'h0;
            plus4_q      <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            req_q        <= req_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            plus4_q      <= plus4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem.IMemReq  = req_q;
    assign imem.IMemAddr = fetch_pc_q;
    assign Instruction   = instr_q;
    assign InstrPC       = instr_pc_q;
    assign InstrPCPlus4  = plus4_q;
    assign InstrValid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table from reset release,
// then a reset asserted while a redirect is draining.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        mem_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;

    int checks;
    int errors;

    fetch_stage_if imem_bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_bus.IMemReady = mem_ready;
    assign imem_bus.IMemData  = mem_ready ? mem_word(imem_bus.IMemAddr) : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clock          (clk),
        .Reset          (rst_n),
        .Stall          (stall),
        .Redirect       (redirect),
        .RedirectTarget (redirect_target),
        .imem           (imem_bus),
        .Instruction    (instruction),
        .InstrPC        (instr_pc),
        .InstrPCPlus4   (instr_pc_plus4),
        .InstrValid     (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_if_id(input string tag, input logic exp_valid, input logic [31:0] exp_pc);
        chk({tag, " valid"}, {31'h0, instr_valid}, {31'h0, exp_valid});
        if (exp_valid) begin
            chk({tag, " instr"}, instruction, mem_word(exp_pc));
            chk({tag, " pc"}, instr_pc, exp_pc);
            chk({tag, " pc4"}, instr_pc_plus4, exp_pc + 32'd4);
        end else begin
            chk({tag, " instr"}, instruction, 32'h0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"}, {31'h0, imem_bus.IMemReq}, 32'h0);
        chk({tag, " addr"}, imem_bus.IMemAddr, 32'h0);
        chk({tag, " instr"}, instruction, 32'h0);
        chk({tag, " pc"}, instr_pc, 32'h0);
        chk({tag, " pc4"}, instr_pc_plus4, 32'h0);
        chk({tag, " valid"}, {31'h0, instr_valid}, 32'h0);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        mem_ready = 1'b0;

        //            stall redir target        rdy  req addr          vld pc
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h04});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h08});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0C});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h10});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h14});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h18});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h1C});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0024, 1'b1, 32'h1C});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0024, 1'b1, 32'h1C});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0024, 1'b1, 32'h20});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0028, 1'b1, 32'h24});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_002C, 1'b1, 32'h28});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0030, 1'b1, 32'h2C});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0034, 1'b1, 32'h30});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0038, 1'b1, 32'h34});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_003C, 1'b1, 32'h38});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h3C});
        vecs.push_back('{1'b0, 1'b1, 32'h103,      1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h100});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0108, 1'b1, 32'h100});
        vecs.push_back('{1'b1, 1'b1, 32'h200,      1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0204, 1'b1, 32'h200});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h300,      1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h400,      1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0404, 1'b1, 32'h400});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0404, 1'b1, 32'h400});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0408, 1'b1, 32'h404});
        vecs.push_back('{1'b0, 1'b1, 32'h500,      1'b0, 1'b1, 32'h0000_0408, 1'b0, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall           = vecs[i].stall;
            redirect        = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            mem_ready       = vecs[i].ready;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d req", i), {31'h0, imem_bus.IMemReq}, {31'h0, vecs[i].exp_req});
            chk($sformatf("v%0d addr", i), imem_bus.IMemAddr, vecs[i].exp_addr);
            chk_if_id($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Reset lands mid-cycle while the 0x500 redirect is draining.
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("drain_rst");
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("drain_rst_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel1 req", {31'h0, imem_bus.IMemReq}, 32'h1);
        chk("rel1 addr", imem_bus.IMemAddr, 32'h0);
        chk_if_id("rel1", 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("rel2 addr", imem_bus.IMemAddr, 32'h4);
        chk_if_id("rel2", 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
